// File: rtl/slc3_io_pkg.sv
// Shared types and defaults for the SLC-3 board input conditioning logic.
package slc3_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/slc3_button_conditioner_debounce.sv
// One pushbutton: polarity normalisation, 2-flop synchronizer and a debounce
// FSM that emits a single pulse per qualified press plus a debounced level.
module button_debounce
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse,
  output logic level
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          pressed_raw;
  logic          sync_meta;
  logic          pressed_sync;
  btn_state_t    state;
  logic [CW-1:0] cnt;

  assign pressed_raw = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Synchronizer comes out of reset as "released" so a held button re-qualifies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta    <= 1'b0;
      pressed_sync <= 1'b0;
    end else begin
      sync_meta    <= pressed_raw;
      pressed_sync <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pressed_sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_sync) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state <= HELD;
            pulse <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!pressed_sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        // A bounce back to pressed returns to HELD silently: no second pulse.
        RELEASE_WAIT: begin
          if (pressed_sync) begin
            state <= HELD;
          end else if (cnt == LAST) begin
            state <= IDLE;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/slc3_button_conditioner.sv
// Board input conditioning for the SLC-3: debounced Run/Continue pulses and
// levels, plus a 2-flop synchronized switch word.
module slc3_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = slc3_io_pkg::DEBOUNCE_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run_raw,
  input  logic        Continue_raw,
  input  logic [15:0] S_raw,
  output logic        Run_pulse,
  output logic        Continue_pulse,
  output logic        Run_level,
  output logic        Continue_level,
  output logic [15:0] S
);

  logic [15:0] s_meta;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_run (
    .clk    (Clk),
    .rst    (Reset),
    .btn_raw(Run_raw),
    .pulse  (Run_pulse),
    .level  (Run_level)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_continue (
    .clk    (Clk),
    .rst    (Reset),
    .btn_raw(Continue_raw),
    .pulse  (Continue_pulse),
    .level  (Continue_level)
  );

  // Switches are level inputs read by software, so only metastability matters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s_meta <= '0;
      S      <= '0;
    end else begin
      s_meta <= S_raw;
      S      <= s_meta;
    end
  end

endmodule
